load_store_unit: RTL and testbench
==================================

# load_store_unit

Core-side initiator for the data-memory request interface. Converts core load/store requests into memory requests:
- generates byte enables and replicated write data;
- stalls the core until the memory responds;
- aligns and sign/zero-extends read data returned one cycle after acceptance.

It sits between the execute stage and the data memory, driving the memory's request/write-enable/byte-enable/address/write-data inputs and consuming its read-data/ready outputs.

## Interface
Parameters: none.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, synchronous, active-high
- core_req_i  input  1  core requests a memory access
- core_we_i  input  1  1 = store, 0 = load
- core_size_i  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- core_addr_i  input  32  byte address
- core_wd_i  input  32  store data, right-justified
- core_rd_o  output  32  extended load result
- core_stall_o  output  1  core must hold request and inputs stable
- misalign_o  output  1  misaligned access flag (only with LSU_MISALIGN_TRAP_EN)
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write enable
- mem_be_o  output  4  memory byte enables
- mem_addr_o  output  32  memory byte address (= core_addr_i)
- mem_wd_o  output  32  memory write data
- mem_rd_i  input  32  memory read data, registered in memory, valid the cycle after acceptance
- mem_ready_i  input  1  memory accepts the request this cycle

## Operation
FSM states:
- IDLE: waiting for a core request.
- WAIT: request issued, not yet accepted.
- DONE: response cycle.

Transitions:
- IDLE, core_req_i=1: mem_req_o=1, core_stall_o=1. If mem_ready_i=1 → DONE, else → WAIT.
- WAIT: mem_req_o=1, core_stall_o=1. mem_ready_i=1 → DONE.
- DONE: mem_req_o=0, core_stall_o=0; core_rd_o valid. Unconditionally → IDLE. A new core request is not considered until IDLE.

Capture and byte lanes:
- On acceptance (mem_req_o & mem_ready_i at a clock edge), register size and addr[1:0] for read extraction.
- mem_we_o = core_we_i whenever mem_req_o=1, else 0.
- Byte enables: B/BU = 4'b0001 << addr[1:0]; H/HU = addr[1] ? 4'b1100 : 4'b0011; W and any other code = 4'b1111.
- Write data: B = {4{wd[7:0]}}; H = {2{wd[15:0]}}; W = wd.

Load extraction from mem_rd_i, using the latched offset:
- B: sign-extend the selected byte. BU: zero-extend it.
- H: sign-extend the selected halfword (addr[1]). HU: zero-extend it.
- W and other codes: full word.

core_rd_o = 0 outside DONE, and in DONE for stores.

## Timing
- Minimum access: 2 cycles, i.e. 1 stall cycle, with mem_ready_i=1 at the first edge. Each extra cycle with mem_ready_i=0 adds one stall cycle.
- While rst_i=1: state ← IDLE, latched size/offset ← 0. mem_req_o, mem_we_o, core_stall_o, misalign_o and core_rd_o are forced to 0. mem_be_o is 0.
- Reset in WAIT or DONE abandons the access; no memory request is issued in the cycle after reset is released unless core_req_i=1.
- Back-to-back requests: DONE → IDLE → new access. Throughput is one access per 2 cycles minimum.
- Core obligation: inputs stable while core_stall_o=1. The LSU does not check this.

## Configuration
Macro LSU_MISALIGN_TRAP_EN.
- Defined: in IDLE, a request is misaligned when it is H/HU with addr[0]=1, or W with addr[1:0]≠0. A misaligned request drives misalign_o=1 combinationally that cycle. No memory request is issued, core_stall_o=0, and the state stays IDLE.
- Undefined: misalign_o tied to 0. Misaligned H forces addr[0]=0 in lane selection; misaligned W ignores addr[1:0] for byte enables and extraction.

## Test plan
- Reset: rst_i=1 with core_req_i=1 → mem_req_o=0, core_stall_o=0, core_rd_o=0. Release → IDLE, request issued the next cycle.
- SB to 0x0000_0102, wd=0x0000_00A5, mem_ready_i=1 → mem_be_o=4'b0100, mem_wd_o=0xA5A5A5A5, mem_we_o=1. Stall for 1 cycle, then DONE.
- LB from 0x0000_0003 with mem_rd_i=0x80FF_0000 in DONE → core_rd_o=0xFFFF_FF80. The same access as LBU → 0x0000_0080.
- LH from 0x0000_0002 with mem_rd_i=0x8001_1234 → core_rd_o=0xFFFF_8001. LW → 0x8001_1234.
- Wait states: mem_ready_i=0 for 3 cycles, then 1 → core_stall_o high for 4 cycles, mem_req_o high for 4 cycles, then DONE. Reset asserted during WAIT → IDLE with mem_req_o=0.
- With LSU_MISALIGN_TRAP_EN: LW from 0x0000_0006 → misalign_o=1, mem_req_o=0, core_stall_o=0. Without the macro → mem_be_o=4'b1111, access completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for the data-memory request interface.
// Generates byte enables and replicated store data, stalls the core until the
// memory accepts, and aligns/extends load data returned in the DONE cycle.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (flag misaligned H/W requests
// instead of issuing them).
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        we_q;

    logic        is_byte_c;
    logic        is_half_c;
    logic        misalign_c;
    logic        issue_c;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [7:0]  rd_byte_c;
    logic [15:0] rd_half_c;
    logic [31:0] rd_ext_c;

    // Decode request size and detect misalignment while idle.
    always_comb begin
        is_byte_c  = (core_size_i == SZ_B) || (core_size_i == SZ_BU);
        is_half_c  = (core_size_i == SZ_H) || (core_size_i == SZ_HU);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_c = (state_q == IDLE) && core_req_i &&
                     ((is_half_c && core_addr_i[0]) ||
                      ((core_size_i == SZ_W) && (core_addr_i[1:0] != 2'b00)));
`else
        misalign_c = 1'b0;
`endif
        issue_c    = !rst_i &&
                     (((state_q == IDLE) && core_req_i && !misalign_c) ||
                      (state_q == WAIT));
    end

    // Byte-enable and replicated write-data generation.
    always_comb begin
        be_c = 4'b1111;
        wd_c = core_wd_i;
        if (is_byte_c) begin
            be_c = 4'b0001 << core_addr_i[1:0];
            wd_c = {4{core_wd_i[7:0]}};
        end else if (is_half_c) begin
            be_c = core_addr_i[1] ? 4'b1100 : 4'b0011;
            wd_c = {2{core_wd_i[15:0]}};
        end
    end

    // Lane select and sign/zero extension of returned load data.
    always_comb begin
        case (off_q)
            2'd0:    rd_byte_c = mem_rd_i[7:0];
            2'd1:    rd_byte_c = mem_rd_i[15:8];
            2'd2:    rd_byte_c = mem_rd_i[23:16];
            default: rd_byte_c = mem_rd_i[31:24];
        endcase
        rd_half_c = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_q)
            SZ_B:    rd_ext_c = {{24{rd_byte_c[7]}}, rd_byte_c};
            SZ_BU:   rd_ext_c = {24'h0, rd_byte_c};
            SZ_H:    rd_ext_c = {{16{rd_half_c[15]}}, rd_half_c};
            SZ_HU:   rd_ext_c = {16'h0, rd_half_c};
            default: rd_ext_c = mem_rd_i;
        endcase
    end

    // Drive memory and core outputs; everything quiet during reset.
    always_comb begin
        mem_req_o    = issue_c;
        core_stall_o = issue_c;
        mem_we_o     = issue_c && core_we_i;
        mem_be_o     = issue_c ? be_c : 4'b0000;
        mem_addr_o   = core_addr_i;
        mem_wd_o     = wd_c;
        misalign_o   = misalign_c && !rst_i;
        core_rd_o    = ((state_q == DONE) && !we_q && !rst_i) ? rd_ext_c : 32'h0;
    end

    // Access FSM plus capture of size/offset/direction on acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
        end else begin
            if (issue_c && mem_ready_i) begin
                size_q <= core_size_i;
                off_q  <= core_addr_i[1:0];
                we_q   <= core_we_i;
            end
            case (state_q)
                IDLE:    if (issue_c) state_q <= mem_ready_i ? DONE : WAIT;
                WAIT:    if (mem_ready_i) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    always #5 clk_i = ~clk_i;

    load_store_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .misalign_o(misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete access: issue cycle, `waits` not-ready cycles, then DONE.
    task automatic access(input string name, input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int waits,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = (waits == 0);
        mem_rd_i    = 32'h0;
        #1;
        check_eq({name, ".req"},   32'(mem_req_o), 32'd1);
        check_eq({name, ".stall"}, 32'(core_stall_o), 32'd1);
        check_eq({name, ".we"},    32'(mem_we_o), 32'(we));
        check_eq({name, ".be"},    32'(mem_be_o), 32'(exp_be));
        check_eq({name, ".addr"},  mem_addr_o, addr);
        check_eq({name, ".rd0"},   core_rd_o, 32'h0);
        if (we) check_eq({name, ".wd"}, mem_wd_o, exp_wd);
        for (int k = 1; k <= waits; k++) begin
            @(negedge clk_i);
            mem_ready_i = (k == waits);
            #1;
            check_eq({name, ".wreq"},   32'(mem_req_o), 32'd1);
            check_eq({name, ".wstall"}, 32'(core_stall_o), 32'd1);
        end
        @(negedge clk_i);
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        mem_rd_i    = rdata;
        #1;
        check_eq({name, ".dstall"}, 32'(core_stall_o), 32'd0);
        check_eq({name, ".dreq"},   32'(mem_req_o), 32'd0);
        check_eq({name, ".rd"},     core_rd_o, exp_rd);
        check_eq({name, ".mis"},    32'(misalign_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = W;
        core_addr_i = 32'h0; core_wd_i = 32'h0; mem_rd_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1;

        // Reset holds everything quiet even with a pending request.
        @(negedge clk_i); @(negedge clk_i);
        #1;
        check_eq("rst.req",   32'(mem_req_o), 32'd0);
        check_eq("rst.stall", 32'(core_stall_o), 32'd0);
        check_eq("rst.rd",    core_rd_o, 32'h0);
        check_eq("rst.be",    32'(mem_be_o), 32'd0);
        check_eq("rst.we",    32'(mem_we_o), 32'd0);
        check_eq("rst.mis",   32'(misalign_o), 32'd0);

        // Release: request goes out right away, completes next cycle.
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_eq("rel.req",   32'(mem_req_o), 32'd1);
        check_eq("rel.stall", 32'(core_stall_o), 32'd1);
        @(negedge clk_i);
        core_req_i = 1'b0; mem_ready_i = 1'b0; mem_rd_i = 32'h1234_5678;
        #1;
        check_eq("rel.dstall", 32'(core_stall_o), 32'd0);
        check_eq("rel.rd",     core_rd_o, 32'h1234_5678);

        access("sb",  1'b1, B,  32'h0000_0102, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 4'b0100, 32'hA5A5_A5A5, 32'h0);
        access("lb",  1'b0, B,  32'h0000_0003, 32'h0,         32'h80FF_0000, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        access("lbu", 1'b0, BU, 32'h0000_0003, 32'h0,         32'h80FF_0000, 0, 4'b1000, 32'h0, 32'h0000_0080);
        access("lh",  1'b0, H,  32'h0000_0002, 32'h0,         32'h8001_1234, 0, 4'b1100, 32'h0, 32'hFFFF_8001);
        access("lw",  1'b0, W,  32'h0000_0000, 32'h0,         32'h8001_1234, 0, 4'b1111, 32'h0, 32'h8001_1234);
        access("lh0", 1'b0, H,  32'h0000_0010, 32'h0,         32'h1234_8765, 0, 4'b0011, 32'h0, 32'hFFFF_8765);
        access("lhu", 1'b0, HU, 32'h0000_0010, 32'h0,         32'h1234_8765, 0, 4'b0011, 32'h0, 32'h0000_8765);
        access("lb1", 1'b0, B,  32'h0000_0001, 32'h0,         32'h0000_7F00, 0, 4'b0010, 32'h0, 32'h0000_007F);
        access("sh",  1'b1, H,  32'h0000_0022, 32'h1234_ABCD, 32'h0,         0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        access("sw",  1'b1, W,  32'h0000_0040, 32'hCAFE_F00D, 32'h0,         0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        access("lww", 1'b0, W,  32'h0000_0044, 32'h0,         32'h0BAD_F00D, 3, 4'b1111, 32'h0, 32'h0BAD_F00D);

        // Reset while waiting abandons the access.
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = W; core_addr_i = 32'h80; mem_ready_i = 1'b0;
        #1;
        check_eq("rw.req", 32'(mem_req_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1; core_req_i = 1'b0;
        #1;
        check_eq("rw.rreq",   32'(mem_req_o), 32'd0);
        check_eq("rw.rstall", 32'(core_stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_eq("rw.idle_req",   32'(mem_req_o), 32'd0);
        check_eq("rw.idle_stall", 32'(core_stall_o), 32'd0);

        // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = W; core_addr_i = 32'h6; mem_ready_i = 1'b1;
        #1;
        check_eq("mis.flag",  32'(misalign_o), 32'd1);
        check_eq("mis.req",   32'(mem_req_o), 32'd0);
        check_eq("mis.stall", 32'(core_stall_o), 32'd0);
        @(negedge clk_i);
        core_req_i = 1'b0;
        #1;
        check_eq("mis.rd", core_rd_o, 32'h0);
`else
        access("mis", 1'b0, W, 32'h0000_0006, 32'h0, 32'h5566_7788, 0, 4'b1111, 32'h0, 32'h5566_7788);
`endif

        @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
